// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM encoding, frame size and default FIFO depth.
package uart_pkg;

  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_ACTIVE   = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;

  typedef enum logic [1:0] {
    DISABLED = ST_DISABLED,
    ACTIVE   = ST_ACTIVE,
    DRAIN    = ST_DRAIN
  } rx_state_e;

  // Start + 8 data + stop: one character time in bit periods.
  localparam int UART_FRAME_BITS = 10;
  localparam int DEFAULT_DEPTH   = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO with combinational head read, flush, and full-with-pop / empty-with-push pass-through.
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  input  logic          flush,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  // A full FIFO still accepts a push when the same cycle frees the head slot.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & (~full | pop_ok) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive controller between uart_rx and the register file: enable sequencing, byte FIFO, sticky flags, interrupt.
// Optional idle timeout is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int CW            = $clog2(DEPTH) + 1,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_rx_en,
  input  logic [31:0]   baud_div,
  input  logic          rx_done_tick,
  input  logic [7:0]    rx_data_in,
  input  logic          rx_error_in,
  input  logic          rx_busy_in,
  output logic          rx_en_out,
  input  logic          pop,
  input  logic          flush,
  input  logic          clear_err,
  input  logic [CW-1:0] irq_thresh,
  output logic [7:0]    rd_data,
  output logic [CW-1:0] fifo_count,
  output logic          empty,
  output logic          full,
  output logic          overrun,
  output logic          frame_err,
  output logic          timeout,
  output logic          irq
);

  rx_state_e state_q, state_d;
  logic      rx_en_q;
  logic      overrun_q;
  logic      frame_err_q;
  logic      irq_q;
  logic      timeout_w;

  logic      rx_on;
  logic      push_req;
  logic      err_tick;
  logic      pop_ok;
  logic      overrun_set;
  logic      thresh_hit;

  // Draining keeps uart_rx enabled until the frame in flight completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DISABLED: if (cfg_rx_en) state_d = ACTIVE;
      ACTIVE: begin
        if (!cfg_rx_en) state_d = rx_busy_in ? DRAIN : DISABLED;
      end
      DRAIN: begin
        if (cfg_rx_en)                        state_d = ACTIVE;
        else if (rx_done_tick || !rx_busy_in) state_d = DISABLED;
      end
      default: state_d = DISABLED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DISABLED;
      rx_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_en_q <= (state_d != DISABLED);
    end
  end

  assign rx_on       = (state_q != DISABLED);
  assign push_req    = rx_done_tick & rx_on & ~rx_error_in;
  assign err_tick    = rx_done_tick & rx_on & rx_error_in;
  assign pop_ok      = pop & ~empty & ~flush;
  assign overrun_set = push_req & full & ~pop & ~flush;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .DW    (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_req),
    .wr_data (rx_data_in),
    .pop     (pop),
    .flush   (flush),
    .rd_data (rd_data),
    .count   (fifo_count),
    .empty   (empty),
    .full    (full)
  );

  // Set events take priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (overrun_set)    overrun_q <= 1'b1;
      else if (clear_err) overrun_q <= 1'b0;
      if (err_tick)       frame_err_q <= 1'b1;
      else if (clear_err) frame_err_q <= 1'b0;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int BITS_TC = UART_FRAME_BITS * TIMEOUT_CHARS;
  localparam int BW      = $clog2(BITS_TC + 1);

  logic [31:0]   tmr_q;
  logic [BW-1:0] bits_q;
  logic          timeout_q;
  logic          hold;
  logic          expire;

  assign hold   = empty | rx_busy_in | push_req | pop_ok | flush;
  assign expire = ~hold & (tmr_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q     <= baud_div;
      bits_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (hold) begin
        tmr_q  <= baud_div;
        bits_q <= '0;
      end else if (expire) begin
        tmr_q  <= baud_div;
        bits_q <= (bits_q == BW'(BITS_TC - 1)) ? '0 : bits_q + BW'(1);
      end else begin
        tmr_q  <= tmr_q - 32'd1;
      end
      if (flush || push_req || pop_ok)
        timeout_q <= 1'b0;
      else if (expire && bits_q == BW'(BITS_TC - 1))
        timeout_q <= 1'b1;
    end
  end

  assign timeout_w = timeout_q;
`else
  logic unused_baud_div;
  assign unused_baud_div = ^baud_div;
  assign timeout_w       = 1'b0;
`endif

  assign thresh_hit = (irq_thresh != '0) && (fifo_count >= irq_thresh);

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= thresh_hit | overrun_q | frame_err_q | timeout_w;
  end

  assign rx_en_out = rx_en_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign timeout   = timeout_w;
  assign irq       = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl; the timeout steps depend on UART_RX_TIMEOUT_EN.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_TIMEOUT_EN
  localparam int TCH = 1;
`else
  localparam int TCH = 4;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_rx_en;
  logic [31:0]   baud_div;
  logic          rx_done_tick;
  logic [7:0]    rx_data_in;
  logic          rx_error_in;
  logic          rx_busy_in;
  logic          rx_en_out;
  logic          pop;
  logic          flush;
  logic          clear_err;
  logic [CW-1:0] irq_thresh;
  logic [7:0]    rd_data;
  logic [CW-1:0] fifo_count;
  logic          empty;
  logic          full;
  logic          overrun;
  logic          frame_err;
  logic          timeout;
  logic          irq;

  int tests    = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DEPTH         (DEPTH),
    .CW            (CW),
    .TIMEOUT_CHARS (TCH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_rx_en    (cfg_rx_en),
    .baud_div     (baud_div),
    .rx_done_tick (rx_done_tick),
    .rx_data_in   (rx_data_in),
    .rx_error_in  (rx_error_in),
    .rx_busy_in   (rx_busy_in),
    .rx_en_out    (rx_en_out),
    .pop          (pop),
    .flush        (flush),
    .clear_err    (clear_err),
    .irq_thresh   (irq_thresh),
    .rd_data      (rd_data),
    .fifo_count   (fifo_count),
    .empty        (empty),
    .full         (full),
    .overrun      (overrun),
    .frame_err    (frame_err),
    .timeout      (timeout),
    .irq          (irq)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic err);
    rx_data_in   = d;
    rx_error_in  = err;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    rx_error_in  = 1'b0;
  endtask

  task automatic pop_one();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q [8];
    rst = 1'b1; cfg_rx_en = 1'b0; baud_div = 32'd3; rx_done_tick = 1'b0;
    rx_data_in = 8'h00; rx_error_in = 1'b0; rx_busy_in = 1'b0; pop = 1'b0;
    flush = 1'b0; clear_err = 1'b0; irq_thresh = '0;
    step(); step();
    check("rst_rx_en", rx_en_out, 0);
    check("rst_count", fifo_count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_timeout", timeout, 0);
    check("rst_irq", irq, 0);
    rst = 1'b0;
    step();

    // Enable and basic ordering
    cfg_rx_en = 1'b1;
    step();
    check("en_rx_en", rx_en_out, 1);
    rx_byte(8'h41, 1'b0);
    rx_byte(8'h42, 1'b0);
    rx_byte(8'h43, 1'b0);
    check("abc_count", fifo_count, 3);
    check("abc_head0", rd_data, 8'h41);
    pop_one();
    check("abc_head1", rd_data, 8'h42);
    pop_one();
    check("abc_head2", rd_data, 8'h43);
    pop_one();
    check("abc_empty", empty, 1);
    check("abc_count0", fifo_count, 0);
    pop_one();
    check("underflow_count", fifo_count, 0);
    check("underflow_ovr", overrun, 0);

    // Threshold interrupt
    irq_thresh = CW'(2);
    rx_byte(8'h01, 1'b0);
    step();
    check("thr_irq_one", irq, 0);
    rx_byte(8'h02, 1'b0);
    check("thr_count2", fifo_count, 2);
    step();
    check("thr_irq_two", irq, 1);
    pop_one();
    step();
    check("thr_irq_pop", irq, 0);
    pop_one();
    irq_thresh = '0;

    // Overrun
    for (int i = 0; i < DEPTH; i++) rx_byte(8'h60 + 8'(i), 1'b0);
    check("fill_full", full, 1);
    check("fill_count", fifo_count, DEPTH);
    rx_byte(8'h55, 1'b0);
    check("ovr_flag", overrun, 1);
    check("ovr_count", fifo_count, DEPTH);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("ovr_clear", overrun, 0);
    pop = 1'b1;
    rx_byte(8'h77, 1'b0);
    pop = 1'b0;
    check("fullpp_ovr", overrun, 0);
    check("fullpp_count", fifo_count, DEPTH);
    for (int i = 0; i < DEPTH - 1; i++) exp_q[i] = 8'h61 + 8'(i);
    exp_q[DEPTH-1] = 8'h77;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain_byte%0d", i), rd_data, exp_q[i]);
      pop_one();
    end
    check("drain_empty", empty, 1);

    // Framing error
    rx_byte(8'hAA, 1'b1);
    check("ferr_flag", frame_err, 1);
    check("ferr_nopush", fifo_count, 0);
    clear_err = 1'b1;
    rx_byte(8'hAB, 1'b1);
    clear_err = 1'b0;
    check("ferr_set_wins", frame_err, 1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("ferr_clear", frame_err, 0);

    // Flush beats push
    rx_byte(8'h10, 1'b0);
    rx_byte(8'h11, 1'b0);
    flush = 1'b1;
    rx_byte(8'h12, 1'b0);
    flush = 1'b0;
    check("flush_count", fifo_count, 0);
    check("flush_empty", empty, 1);

    // Drain on disable
    rx_busy_in = 1'b1;
    cfg_rx_en  = 1'b0;
    step();
    check("drain_rx_en", rx_en_out, 1);
    step();
    check("drain_rx_en2", rx_en_out, 1);
    rx_byte(8'h5A, 1'b0);
    rx_busy_in = 1'b0;
    check("drain_push", fifo_count, 1);
    check("drain_data", rd_data, 8'h5A);
    check("drain_off", rx_en_out, 0);

    // Ticks while disabled are ignored
    rx_byte(8'h33, 1'b0);
    rx_byte(8'hEE, 1'b1);
    check("dis_count", fifo_count, 1);
    check("dis_ferr", frame_err, 0);

    // Idle timeout
    flush = 1'b1;
    step();
    flush = 1'b0;
    cfg_rx_en = 1'b1;
    step();
    rx_byte(8'h99, 1'b0);
`ifdef UART_RX_TIMEOUT_EN
    for (int i = 0; i < 39; i++) step();
    check("to_before", timeout, 0);
    step();
    check("to_set", timeout, 1);
    pop_one();
    check("to_clear", timeout, 0);
`else
    for (int i = 0; i < 60; i++) step();
    check("to_absent", timeout, 0);
    pop_one();
`endif
    check("final_count", fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller placed between the uart_rx deserializer and the APB register file.
- Sequences the deserializer's enable so that disabling never truncates a frame in progress.
- Buffers received bytes in a DEPTH-entry FIFO and filters framing-error frames.
- Tracks overrun and framing-error sticky flags and raises one level interrupt (threshold, error, optional idle timeout).

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- CW, $clog2(DEPTH)+1, width of the count and threshold fields.
- TIMEOUT_CHARS, 4, idle character-times before timeout (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_rx_en  in  1  software receive enable (level)
- baud_div  in  32  same value as fed to uart_rx; bit period = baud_div+1 clocks
- rx_done_tick  in  1  uart_rx frame-complete pulse
- rx_data_in  in  8  uart_rx rx_data_out
- rx_error_in  in  1  uart_rx rx_error (valid with rx_done_tick)
- rx_busy_in  in  1  uart_rx rx_busy
- rx_en_out  out  1  drives uart_rx rx_en
- pop  in  1  read strobe from register file
- flush  in  1  FIFO flush strobe
- clear_err  in  1  clears sticky error flags
- irq_thresh  in  CW  fill level for interrupt; 0 disables the threshold source
- rd_data  out  8  FIFO head (combinational read of the entry at rd_ptr)
- fifo_count  out  CW  current occupancy
- empty / full  out  1 each
- overrun  out  1  sticky: byte dropped because the FIFO was full
- frame_err  out  1  sticky: frame received with a bad stop bit
- timeout  out  1  idle-timeout flag (constant 0 when the feature is compiled out)
- irq  out  1  interrupt level

Behaviour:
- Reset: state=DISABLED; rx_en_out=0; pointers=0; fifo_count=0; empty=1; full=0; overrun=0; frame_err=0; timeout=0; irq=0; rd_data=entry 0 (contents don't-care).
- FSM states: DISABLED, ACTIVE, DRAIN.
  - DISABLED -> ACTIVE when cfg_rx_en=1.
  - ACTIVE -> DISABLED when cfg_rx_en=0 and rx_busy_in=0.
  - ACTIVE -> DRAIN when cfg_rx_en=0 and rx_busy_in=1.
  - DRAIN -> ACTIVE when cfg_rx_en=1 (re-enable has priority).
  - Otherwise DRAIN -> DISABLED when rx_done_tick=1 or rx_busy_in=0.
- rx_en_out is registered: 1 iff next state is ACTIVE or DRAIN, so it asserts 1 cycle after cfg_rx_en rises.
- Push (registered, 1-cycle latency to the count) requires all of:
  - rx_done_tick=1;
  - state ACTIVE or DRAIN;
  - rx_error_in=0.
- Done tick with rx_error_in=1: no push; frame_err<=1.
- Push while full and no pop that cycle: byte dropped; overrun<=1; FIFO unchanged.
- Pop: when pop=1 and empty=0, advance rd_ptr and decrement the count. Pop on empty is ignored (no underflow, no flag).
- Simultaneous push and pop: both take effect and the count is unchanged. This holds when full (no overrun) and when empty with pop (pop ignored, push lands).
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- flush: clears pointers, count and timeout next cycle. Sticky flags are untouched. flush beats a same-cycle push or pop (the incoming byte is discarded).
- clear_err: clears overrun and frame_err. A same-cycle set event wins over the clear.
- Done ticks arriving in DISABLED are ignored; no flags change.
- irq (registered) = (irq_thresh!=0 && fifo_count>=irq_thresh) | overrun | frame_err | timeout.
- Reset mid-frame: the controller returns to DISABLED and drops rx_en_out. uart_rx's own state is not this block's concern.

Optional Feature:
Macro UART_RX_TIMEOUT_EN.
- Defined:
  - A bit-time down-counter reloads baud_div on reaching 0.
  - A bit counter counts 10*TIMEOUT_CHARS expiries; on terminal count, timeout<=1.
  - Both counters are held at their reload values while any of these hold: empty=1, rx_busy_in=1, or a push/pop/flush this cycle.
  - timeout clears on pop, push or flush.
- Undefined: no counters are synthesized and timeout is tied to 0.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams (DISABLED/ACTIVE/DRAIN);
  - UART_FRAME_BITS=10;
  - default DEPTH.
- Sub-module uart_sync_fifo: generic synchronous FIFO with push/pop/flush/count/full/empty and simultaneous-access rules as above. The controller instantiates it and adds the gating, flag and FSM logic.

Test Plan:
- Enable, then 3 done ticks with data 0x41, 0x42, 0x43 and error=0.
  - fifo_count=3.
  - Pops return 0x41, 0x42, 0x43 in order; empty=1 after.
- irq_thresh=2: first push gives irq=0; second push gives irq=1 one cycle later; one pop drops irq to 0.
- Fill with DEPTH bytes, then push 0x55 alone.
  - overrun=1; count=DEPTH; 0x55 absent.
  - Next push with simultaneous pop: overrun unchanged, count=DEPTH.
- Done tick with rx_error_in=1 and data 0xAA.
  - frame_err=1; no push.
  - clear_err concurrent with another error tick leaves frame_err=1.
- cfg_rx_en dropped while rx_busy_in=1: state DRAIN, rx_en_out stays 1. The next done tick pushes its byte, then rx_en_out=0.
- With UART_RX_TIMEOUT_EN, baud_div=3, TIMEOUT_CHARS=1, one byte held in the FIFO and rx_busy_in=0:
  - timeout=1 after 40 idle cycles;
  - a pop clears it.
